alu_mul_sequencer: RTL

- Multi-cycle 8-bit multiply initiator that drives the shared combinational ALU through its operand/opcode interface and consumes `Out` as the result.
- Implements shift-add multiply (low 8 bits of product) using only the ALU `ADD`, `LSH` and `RSH` operations, one ALU op per cycle.
- Sits beside the datapath; the control unit pulses `Start` for a `MUL`-class instruction and stalls until `Done`.

---
 rtl/alu_mul_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-add 8-bit multiplier that borrows the shared combinational ALU one op per cycle.
// Only ADD, LSH and RSH are issued; the product is the low W bits of InA*InB.

package definitions;
  typedef enum logic [3:0] {
    ADD = 4'h0,
    SUB = 4'h1,
    LSH = 4'h2,
    RSH = 4'h3
  } op_mne;
endpackage

module alu_mul_sequencer
  import definitions::*;
#(
  parameter int W   = 8,
  parameter int Ops = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [W-1:0]   InA,
  input  logic [W-1:0]   InB,
  output logic           Busy,
  output logic           Done,
  output logic [W-1:0]   Product,
  output logic [W-1:0]   AluA,
  output logic [W-1:0]   AluB,
  output logic [Ops-1:0] AluOp,
  input  logic [W-1:0]   AluOut
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDS,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [W-1:0]   product_q, product_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [Ops-1:0] alu_op_q, alu_op_d;
  logic           busy_q, done_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          mcand_d  = InA;
          mplier_d = InB;
          acc_d    = '0;
          cnt_d    = '0;
          if (InB == '0)   state_d = S_DONE;
          else if (InB[0]) state_d = S_ADDS;
          else             state_d = S_SHL;
        end
      end
      S_ADDS: begin
        acc_d   = AluOut;
        state_d = S_SHL;
      end
      S_SHL: begin
        mcand_d = AluOut;
        state_d = S_SHR;
      end
      S_SHR: begin
        mplier_d = AluOut;
        cnt_d    = cnt_q + 3'd1;
        if (AluOut == '0 || cnt_q == 3'd7) state_d = S_DONE;
        else if (AluOut[0])                state_d = S_ADDS;
        else                               state_d = S_SHL;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    product_d = (state_d == S_DONE && state_q != S_DONE) ? acc_d : product_q;

    // ALU drive is registered, so it is decoded from the state being entered.
    alu_a_d  = '0;
    alu_b_d  = '0;
    alu_op_d = Ops'(ADD);
    case (state_d)
      S_ADDS: begin
        alu_a_d = acc_d;
        alu_b_d = mcand_d;
      end
      S_SHL: begin
        alu_a_d  = mcand_d;
        alu_op_d = Ops'(LSH);
      end
      S_SHR: begin
        alu_a_d  = mplier_d;
        alu_op_d = Ops'(RSH);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= Ops'(ADD);
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Product = product_q;
  assign AluA    = alu_a_q;
  assign AluB    = alu_b_q;
  assign AluOp   = alu_op_q;

endmodule
